// File: rtl/ga_run_sequencer.sv
// Sequences NUM_RUNS GA engine runs: preloads the population, waits for completion,
// captures per-run and overall-best results. Optional watchdog: GA_RUN_SEQ_WATCHDOG_EN.
module ga_run_sequencer #(
  parameter int CHROMOSOME_WIDTH = 16,
  parameter int FITNESS_WIDTH    = 14,
  parameter int POPULATION_SIZE  = 16,
  parameter int NUM_RUNS         = 4,
  parameter int TIMEOUT_CYCLES   = 65535
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               pl_we,
  input  logic [$clog2(POPULATION_SIZE)-1:0] pl_addr,
  input  logic [CHROMOSOME_WIDTH-1:0]        pl_data,
  input  logic                               cmd_start,
  input  logic                               cmd_abort,
  input  logic                               ga_init_ready,
  input  logic [$clog2(POPULATION_SIZE)-1:0] ga_init_idx,
  input  logic                               ga_done,
  input  logic                               ga_perfect,
  input  logic [CHROMOSOME_WIDTH-1:0]        ga_best_chr,
  input  logic [FITNESS_WIDTH-1:0]           ga_best_fit,
  output logic                               ga_start,
  output logic                               ga_load,
  output logic [CHROMOSOME_WIDTH-1:0]        ga_data,
  output logic                               seq_busy,
  output logic                               seq_done,
  output logic [7:0]                         run_idx,
  output logic                               res_valid,
  output logic [CHROMOSOME_WIDTH-1:0]        res_best_chr,
  output logic [FITNESS_WIDTH-1:0]           res_best_fit,
  output logic                               res_perfect,
  output logic                               res_timeout,
  output logic [CHROMOSOME_WIDTH-1:0]        overall_best_chr,
  output logic [FITNESS_WIDTH-1:0]           overall_best_fit
);
  localparam int AW = $clog2(POPULATION_SIZE);

  typedef enum logic [2:0] {S_IDLE, S_START, S_LOAD, S_RUN, S_CAPTURE, S_FINISH} state_t;

  state_t                      state_q;
  logic [CHROMOSOME_WIDTH-1:0] mem [POPULATION_SIZE];
  logic [AW-1:0]               load_cnt_q;
  logic                        ga_start_q, ga_load_q, seq_busy_q, seq_done_q, res_valid_q;
  logic                        res_perfect_q;
  logic [CHROMOSOME_WIDTH-1:0] ga_data_q, res_chr_q, ob_chr_q;
  logic [FITNESS_WIDTH-1:0]    res_fit_q, ob_fit_q;
  logic [7:0]                  run_idx_q;
  logic                        wd_hit;
  logic                        last_run;

  // Preload RAM is never reset; a same-cycle read sees the pre-write value.
  always_ff @(posedge clk) begin
    if (pl_we) mem[pl_addr] <= pl_data;
  end

`ifdef GA_RUN_SEQ_WATCHDOG_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cyc_q;
  logic          res_timeout_q;
  assign wd_hit      = (cyc_q == CW'(TIMEOUT_CYCLES - 1));
  assign res_timeout = res_timeout_q;
`else
  assign wd_hit      = 1'b0;
  assign res_timeout = 1'b0;
`endif

  assign last_run = (run_idx_q == 8'(NUM_RUNS - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      load_cnt_q    <= '0;
      ga_start_q    <= 1'b0;
      ga_load_q     <= 1'b0;
      ga_data_q     <= '0;
      seq_busy_q    <= 1'b0;
      seq_done_q    <= 1'b0;
      run_idx_q     <= '0;
      res_valid_q   <= 1'b0;
      res_chr_q     <= '0;
      res_fit_q     <= '0;
      res_perfect_q <= 1'b0;
      ob_chr_q      <= '0;
      ob_fit_q      <= '0;
`ifdef GA_RUN_SEQ_WATCHDOG_EN
      cyc_q         <= '0;
      res_timeout_q <= 1'b0;
`endif
    end else begin
      ga_start_q  <= 1'b0;
      ga_load_q   <= 1'b0;
      res_valid_q <= 1'b0;
      seq_done_q  <= 1'b0;
`ifdef GA_RUN_SEQ_WATCHDOG_EN
      cyc_q       <= '0;
`endif
      case (state_q)
        S_IDLE: if (cmd_start) begin
          state_q    <= S_START;
          ga_start_q <= 1'b1;
          seq_busy_q <= 1'b1;
          run_idx_q  <= '0;
          ob_fit_q   <= '0;
          ob_chr_q   <= '0;
        end
        S_START: begin
          load_cnt_q <= '0;
          state_q    <= S_LOAD;
        end
        // Load only the index the engine asks for; a mismatched request just stalls.
        S_LOAD: if (ga_init_ready && ga_init_idx == load_cnt_q) begin
          ga_load_q  <= 1'b1;
          ga_data_q  <= mem[load_cnt_q];
          load_cnt_q <= load_cnt_q + 1'b1;
          if (load_cnt_q == AW'(POPULATION_SIZE - 1)) state_q <= S_RUN;
        end
        S_RUN: begin
`ifdef GA_RUN_SEQ_WATCHDOG_EN
          cyc_q <= cyc_q + 1'b1;
`endif
          if (ga_done || wd_hit) begin
            state_q       <= S_CAPTURE;
            res_valid_q   <= 1'b1;
            res_chr_q     <= ga_best_chr;
            res_fit_q     <= ga_best_fit;
            res_perfect_q <= ga_perfect;
`ifdef GA_RUN_SEQ_WATCHDOG_EN
            res_timeout_q <= !ga_done;
`endif
            if (run_idx_q == 8'd0 || ga_best_fit > ob_fit_q) begin
              ob_fit_q <= ga_best_fit;
              ob_chr_q <= ga_best_chr;
            end
          end
        end
        S_CAPTURE: if (last_run || res_perfect_q) begin
          state_q    <= S_FINISH;
          seq_done_q <= 1'b1;
        end else begin
          run_idx_q  <= run_idx_q + 8'd1;
          state_q    <= S_START;
          ga_start_q <= 1'b1;
        end
        S_FINISH: begin
          state_q    <= S_IDLE;
          seq_busy_q <= 1'b0;
        end
        default: begin
          state_q    <= S_IDLE;
          seq_busy_q <= 1'b0;
        end
      endcase
      // Abort overrides everything decided above, including a same-cycle ga_done.
      if (cmd_abort && state_q != S_IDLE) begin
        state_q     <= S_IDLE;
        seq_busy_q  <= 1'b0;
        ga_start_q  <= 1'b0;
        ga_load_q   <= 1'b0;
        res_valid_q <= 1'b0;
        seq_done_q  <= 1'b0;
      end
    end
  end

  assign ga_start         = ga_start_q;
  assign ga_load          = ga_load_q;
  assign ga_data          = ga_data_q;
  assign seq_busy         = seq_busy_q;
  assign seq_done         = seq_done_q;
  assign run_idx          = run_idx_q;
  assign res_valid        = res_valid_q;
  assign res_best_chr     = res_chr_q;
  assign res_best_fit     = res_fit_q;
  assign res_perfect      = res_perfect_q;
  assign overall_best_chr = ob_chr_q;
  assign overall_best_fit = ob_fit_q;
endmodule

// File: tb/tb_ga_run_sequencer.sv
// Directed bench for ga_run_sequencer: preload, multi-run sequence, perfect early exit,
// abort, reset override and watchdog (or no-watchdog) behaviour.
module tb_ga_run_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pl_we = 1'b0;
  logic [3:0]  pl_addr = '0;
  logic [15:0] pl_data = '0;
  logic        cmd_start = 1'b0, cmd_abort = 1'b0;
  logic        ga_init_ready = 1'b0;
  logic [3:0]  ga_init_idx = '0;
  logic        ga_done = 1'b0, ga_perfect = 1'b0;
  logic [15:0] ga_best_chr = '0;
  logic [13:0] ga_best_fit = '0;
  logic        ga_start, ga_load, seq_busy, seq_done, res_valid, res_perfect, res_timeout;
  logic [15:0] ga_data, res_best_chr, overall_best_chr;
  logic [13:0] res_best_fit, overall_best_fit;
  logic [7:0]  run_idx;

  int nvec = 0, nerr = 0;
  int nload = 0, nres = 0;
  logic [15:0] mem_m [16];

  ga_run_sequencer #(.TIMEOUT_CYCLES(50)) dut (
    .clk(clk), .rst(rst), .pl_we(pl_we), .pl_addr(pl_addr), .pl_data(pl_data),
    .cmd_start(cmd_start), .cmd_abort(cmd_abort),
    .ga_init_ready(ga_init_ready), .ga_init_idx(ga_init_idx),
    .ga_done(ga_done), .ga_perfect(ga_perfect), .ga_best_chr(ga_best_chr), .ga_best_fit(ga_best_fit),
    .ga_start(ga_start), .ga_load(ga_load), .ga_data(ga_data),
    .seq_busy(seq_busy), .seq_done(seq_done), .run_idx(run_idx),
    .res_valid(res_valid), .res_best_chr(res_best_chr), .res_best_fit(res_best_fit),
    .res_perfect(res_perfect), .res_timeout(res_timeout),
    .overall_best_chr(overall_best_chr), .overall_best_fit(overall_best_fit)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ga_load)   nload++;
    if (res_valid) nres++;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got running exp finished");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_start();
    bit seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      tick();
      if (ga_start) seen = 1;
    end
    chk("ga_start_seen", 32'(seen), 32'd1);
  endtask

  // Engine model: request indices 0..n-1 in order, one ga_load expected per request.
  task automatic load_n(input int n, input bit poke5);
    for (int i = 0; i < n; i++) begin
      bit got = 0;
      ga_init_ready = 1'b1;
      ga_init_idx   = 4'(i);
      if (poke5 && i == 5) begin
        pl_we = 1'b1; pl_addr = 4'd5; pl_data = 16'hBEEF;
      end
      for (int k = 0; k < 6 && !got; k++) begin
        tick();
        pl_we = 1'b0;
        if (ga_load) got = 1;
      end
      if (!got) chk($sformatf("ga_load_idx%0d", i), 32'(got), 32'd1);
      else chk($sformatf("ga_data_idx%0d", i), 32'(ga_data), 32'(mem_m[i]));
      if (poke5 && i == 5) mem_m[5] = 16'hBEEF;
    end
    ga_init_ready = 1'b0;
  endtask

  task automatic finish_run(input logic [13:0] fit, input logic [15:0] chr, input bit perf,
                            input logic [7:0] exp_idx, input logic [13:0] exp_ob,
                            input logic [15:0] exp_obc);
    tick(); tick();
    ga_done = 1'b1; ga_best_fit = fit; ga_best_chr = chr; ga_perfect = perf;
    tick();
    ga_done = 1'b0; ga_perfect = 1'b0;
    chk("res_valid", 32'(res_valid), 32'd1);
    chk("res_best_fit", 32'(res_best_fit), 32'(fit));
    chk("res_best_chr", 32'(res_best_chr), 32'(chr));
    chk("res_perfect", 32'(res_perfect), 32'(perf));
    chk("res_timeout", 32'(res_timeout), 32'd0);
    chk("run_idx", 32'(run_idx), 32'(exp_idx));
    chk("overall_best_fit", 32'(overall_best_fit), 32'(exp_ob));
    chk("overall_best_chr", 32'(overall_best_chr), 32'(exp_obc));
  endtask

  initial begin
    int n0, r0, cnt;
    bit flag;
    logic [13:0] fits [4];
    logic [13:0] obs_exp [4];
    logic [15:0] obc_exp [4];
    fits    = '{14'd100, 14'd250, 14'd200, 14'd250};
    obs_exp = '{14'd100, 14'd250, 14'd250, 14'd250};
    obc_exp = '{16'hA000, 16'hA001, 16'hA001, 16'hA001};

    // Reset state
    tick(); tick();
    chk("rst_seq_busy", 32'(seq_busy), 32'd0);
    chk("rst_ga_start", 32'(ga_start), 32'd0);
    chk("rst_ga_load", 32'(ga_load), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_run_idx", 32'(run_idx), 32'd0);
    chk("rst_overall_fit", 32'(overall_best_fit), 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 16; i++) begin
      mem_m[i] = 16'h0001 + 16'(i) * 16'h090E;
      pl_we = 1'b1; pl_addr = 4'(i); pl_data = mem_m[i];
      tick();
    end
    pl_we = 1'b0;

    // Four-run sequence
    cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
    chk("start_ga_start", 32'(ga_start), 32'd1);
    chk("start_busy", 32'(seq_busy), 32'd1);
    tick();
    chk("ga_start_one_cycle", 32'(ga_start), 32'd0);
    // Out-of-order request must stall without loading
    ga_init_ready = 1'b1; ga_init_idx = 4'd3;
    flag = 0;
    for (int k = 0; k < 4; k++) begin tick(); if (ga_load) flag = 1; end
    chk("mismatch_no_load", 32'(flag), 32'd0);
    r0 = nres;
    for (int r = 0; r < 4; r++) begin
      if (r > 0) wait_start();
      n0 = nload;
      load_n(16, r == 1);
      tick();
      chk("load_pulses_16", 32'(nload - n0), 32'd16);
      chk("busy_in_run", 32'(seq_busy), 32'd1);
      finish_run(fits[r], 16'hA000 + 16'(r), 1'b0, 8'(r), obs_exp[r], obc_exp[r]);
    end
    tick();
    chk("seq_done_pulse", 32'(seq_done), 32'd1);
    chk("busy_in_finish", 32'(seq_busy), 32'd1);
    tick();
    chk("seq_done_cleared", 32'(seq_done), 32'd0);
    chk("idle_busy", 32'(seq_busy), 32'd0);
    chk("res_valid_count", 32'(nres - r0), 32'd4);

    // Perfect result ends the sequence early
    cmd_start = 1'b1; tick(); cmd_start = 1'b0;
    chk("p_ga_start", 32'(ga_start), 32'd1);
    chk("p_overall_cleared", 32'(overall_best_fit), 32'd0);
    load_n(16, 1'b0);
    finish_run(14'd10, 16'h1111, 1'b0, 8'd0, 14'd10, 16'h1111);
    wait_start();
    load_n(16, 1'b0);
    finish_run(14'd20, 16'h2222, 1'b1, 8'd1, 14'd20, 16'h2222);
    tick();
    chk("p_seq_done", 32'(seq_done), 32'd1);
    chk("p_run_idx", 32'(run_idx), 32'd1);
    flag = 0;
    for (int k = 0; k < 5; k++) begin tick(); if (ga_start) flag = 1; end
    chk("p_no_run2_start", 32'(flag), 32'd0);

    // Abort mid-load at load_cnt=7
    cmd_start = 1'b1; tick(); cmd_start = 1'b0;
    load_n(7, 1'b0);
    cmd_abort = 1'b1; ga_init_ready = 1'b1; ga_init_idx = 4'd7;
    tick();
    cmd_abort = 1'b0; ga_init_ready = 1'b0;
    chk("abort_busy", 32'(seq_busy), 32'd0);
    chk("abort_no_load", 32'(ga_load), 32'd0);
    flag = 0;
    for (int k = 0; k < 4; k++) begin tick(); if (seq_done || res_valid) flag = 1; end
    chk("abort_no_done", 32'(flag), 32'd0);
    cmd_start = 1'b1; tick(); cmd_start = 1'b0;
    chk("restart_run_idx", 32'(run_idx), 32'd0);
    load_n(16, 1'b0);
    finish_run(14'd77, 16'h7777, 1'b0, 8'd0, 14'd77, 16'h7777);
    wait_start();
    load_n(16, 1'b0);
    tick();

    // Reset in RUN together with ga_done and cmd_start
    rst = 1'b0; ga_done = 1'b1; cmd_start = 1'b1;
    tick();
    rst = 1'b1; ga_done = 1'b0; cmd_start = 1'b0;
    chk("rrst_res_valid", 32'(res_valid), 32'd0);
    chk("rrst_busy", 32'(seq_busy), 32'd0);
    chk("rrst_run_idx", 32'(run_idx), 32'd0);
    chk("rrst_overall_fit", 32'(overall_best_fit), 32'd0);
    chk("rrst_overall_chr", 32'(overall_best_chr), 32'd0);
    chk("rrst_res_fit", 32'(res_best_fit), 32'd0);

    // Watchdog behaviour with TIMEOUT_CYCLES=50
    cmd_start = 1'b1; tick(); cmd_start = 1'b0;
    load_n(16, 1'b0);
    ga_best_fit = 14'h123; ga_best_chr = 16'h5A5A;
`ifdef GA_RUN_SEQ_WATCHDOG_EN
    cnt = 0;
    while (!res_valid && cnt < 200) begin tick(); cnt++; end
    chk("wd_cycles", 32'(cnt), 32'd50);
    chk("wd_timeout", 32'(res_timeout), 32'd1);
    chk("wd_res_fit", 32'(res_best_fit), 32'h123);
    chk("wd_res_chr", 32'(res_best_chr), 32'h5A5A);
    cmd_abort = 1'b1; tick(); cmd_abort = 1'b0;
`else
    cnt = 0;
    flag = 0;
    for (int k = 0; k < 80; k++) begin tick(); if (res_valid) flag = 1; cnt++; end
    chk("nowd_no_result", 32'(flag), 32'd0);
    chk("nowd_still_busy", 32'(seq_busy), 32'd1);
    chk("nowd_timeout_zero", 32'(res_timeout), 32'd0);
    cmd_abort = 1'b1; tick(); cmd_abort = 1'b0;
`endif
    chk("final_idle", 32'(seq_busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/ga_run_sequencer.md
GA_RUN_SEQUENCER -- requirements
Module: ga_run_sequencer

Interface
REQ-001 Parameters (name, default, meaning): CHROMOSOME_WIDTH, 16, chromosome bits; FITNESS_WIDTH, 14, fitness bits; POPULATION_SIZE, 16, chromosomes per run (power of 2, >=2); NUM_RUNS, 4, GA runs per sequence (1..256); TIMEOUT_CYCLES, 65535, watchdog limit per run.
REQ-002 Ports (name, direction, width, meaning): clk, in, 1, single clock; rst, in, 1, synchronous active-low reset, sampled on rising clk.
REQ-003 pl_we in 1, pl_addr in $clog2(POPULATION_SIZE), pl_data in CHROMOSOME_WIDTH: preload RAM write port.
REQ-004 cmd_start in 1: start sequence pulse; cmd_abort in 1: abort sequence.
REQ-005 ga_init_ready in 1 plus ga_init_idx in $clog2(POPULATION_SIZE): engine ready for chromosome ga_init_idx.
REQ-006 ga_done in 1, ga_perfect in 1, ga_best_chr in CHROMOSOME_WIDTH, ga_best_fit in FITNESS_WIDTH: engine status.
REQ-007 ga_start out 1, ga_load out 1, ga_data out CHROMOSOME_WIDTH: engine control.
REQ-008 seq_busy out 1, seq_done out 1 (one-cycle pulse), run_idx out 8: sequence status.
REQ-009 res_valid out 1 (one-cycle pulse), res_best_chr, res_best_fit, res_perfect out 1, res_timeout out 1: per-run result.
REQ-010 overall_best_chr, overall_best_fit: best across completed runs of current sequence.

Function
REQ-011 States: IDLE, START, LOAD, RUN, CAPTURE, FINISH.
REQ-012 IDLE: cmd_start=1 -> START; clears run_idx, overall_best_fit, overall_best_chr; cmd_start ignored in other states.
REQ-013 START: ga_start=1 for exactly one cycle; load_cnt:=0; next LOAD.
REQ-014 LOAD: when ga_init_ready=1 and ga_init_idx==load_cnt, next cycle ga_load=1 for one cycle with ga_data=mem[load_cnt]; load_cnt++; no further ga_load until ga_init_idx!=previous load_cnt or ga_init_ready deasserts.
REQ-015 ga_init_idx mismatch with load_cnt: no ga_load; sequencer waits (no skip, no error).
REQ-016 After POPULATION_SIZE loads -> RUN; load_cnt wraps to 0 without overflow into RUN decision.
REQ-017 RUN: cycle counter increments per cycle; ga_done=1 -> CAPTURE with timeout flag 0.
REQ-018 CAPTURE (one cycle): res_valid=1; res_* := ga_best_chr, ga_best_fit, ga_perfect, timeout flag; overall_best updated if ga_best_fit > overall_best_fit (strict, unsigned; first run always updates).
REQ-019 After CAPTURE: if run_idx==NUM_RUNS-1 or res_perfect=1 -> FINISH, else run_idx++ and -> START.
REQ-020 FINISH: seq_done=1 one cycle; -> IDLE.
REQ-021 seq_busy=1 in every state except IDLE.
REQ-022 cmd_abort=1 in any non-IDLE state -> IDLE next cycle; no res_valid, no seq_done; ga_start/ga_load forced 0; abort wins over simultaneous ga_done.
REQ-023 pl_we writes in any state; write to address being read in same cycle returns old data.
REQ-024 ga_done in START or LOAD is ignored.

Reset
REQ-025 rst=0 at rising clk: state IDLE; all outputs 0; load_cnt, cycle counter, run_idx, overall_best_* = 0; preload RAM contents not cleared.
REQ-026 Reset mid-run overrides all inputs, including cmd_start and ga_done in same cycle.

Configuration
REQ-027 Macro GA_RUN_SEQ_WATCHDOG_EN defined: in RUN, cycle counter reaching TIMEOUT_CYCLES without ga_done -> CAPTURE with res_timeout=1, res_* taken from current ga_best_*.
REQ-028 Macro undefined: no watchdog counter logic; RUN waits for ga_done indefinitely; res_timeout tied 0.

Verification
REQ-029 Preload mem[i]=16'h0001,16'h090F,... (16 values); cmd_start; engine model requests idx 0..15 -> ga_data matches mem[i] each ga_load, exactly 16 ga_load pulses per run.
REQ-030 NUM_RUNS=4, model returns fitness 100,250,200,250 -> 4 res_valid pulses, overall_best_fit=250 from run 1, seq_done after run 3.
REQ-031 Run 1 returns ga_perfect=1 -> res_perfect=1, seq_done one cycle after that CAPTURE, run_idx=1, no run 2 ga_start.
REQ-032 Watchdog on, TIMEOUT_CYCLES=50, model never asserts ga_done -> res_valid with res_timeout=1 at cycle 50 of RUN; macro off -> busy indefinitely.
REQ-033 cmd_abort during LOAD at load_cnt=7 -> IDLE next cycle, seq_busy=0, no seq_done; new cmd_start restarts at run_idx=0, load_cnt=0.
REQ-034 rst=0 during RUN with ga_done=1 same cycle -> no res_valid, all outputs 0 next cycle.
